// File: rtl/instr_pkg.sv
// Shared RV32 instruction-field constants used across the pipeline.
package instr_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/write_back_stage_pkg.sv
// Shared write-back package: register-file source selection produced by the decoder.
package write_back_stage_pkg;

  typedef enum logic [1:0] {
    WRITE_BACK_SEL_ALU = 2'd0,
    WRITE_BACK_SEL_MEM = 2'd1,
    WRITE_BACK_SEL_PC  = 2'd2
  } write_back_select_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction: picks the byte/halfword addressed by the
// load and sign- or zero-extends it to XLEN according to funct3.
module load_extend
  import instr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_low,
  output logic [XLEN-1:0] ext_data
);

  localparam int LANES = XLEN / 8;

  logic [7:0]  byte_lane [LANES];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign byte_lane[gi] = mem_rdata[gi*8 +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[addr_low];
  // Halfword loads are naturally aligned; the low offset bit plays no part.
  assign half_sel = addr_low[1] ? {byte_lane[3], byte_lane[2]}
                                : {byte_lane[1], byte_lane[0]};

  always_comb begin
    ext_data = mem_rdata;
    case (funct3)
      FUNCT3_LB:  ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      FUNCT3_LBU: ext_data = {{(XLEN-8){1'b0}}, byte_sel};
      FUNCT3_LH:  ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      FUNCT3_LHU: ext_data = {{(XLEN-16){1'b0}}, half_sel};
      default:    ext_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/write_back_stage.sv
// RV32 write-back stage: drives the register-file write port, waiting for load
// data when needed. Optional retired-instruction counter under WB_INSTRET_EN.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write_en,
  input  write_back_select_t    in_reg_store_sel,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_pc_plus4,
  input  logic [2:0]            in_load_funct3,
  input  logic [1:0]            in_addr_low,
  input  logic                  mem_rdata_valid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
`ifdef WB_INSTRET_EN
  output logic [63:0]           instret,
`endif
  output logic                  retire
);

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

  wb_state_t             state_reg;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            addr_low_reg;
  logic [XLEN-1:0]       load_data;
  logic                  is_load;

  assign in_ready = (state_reg == WB_IDLE);
  assign is_load  = in_reg_write_en && (in_reg_store_sel == WRITE_BACK_SEL_MEM);

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .mem_rdata (mem_rdata),
    .funct3    (funct3_reg),
    .addr_low  (addr_low_reg),
    .ext_data  (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= WB_IDLE;
      rd_reg       <= '0;
      funct3_reg   <= '0;
      addr_low_reg <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire       <= 1'b0;
    end else begin
      rf_we  <= 1'b0;
      retire <= 1'b0;
      case (state_reg)
        WB_IDLE: begin
          if (in_valid) begin
            if (is_load) begin
              rd_reg       <= in_rd;
              funct3_reg   <= in_load_funct3;
              addr_low_reg <= in_addr_low;
              state_reg    <= WB_WAIT_MEM;
            end else begin
              rf_we    <= in_reg_write_en && (in_rd != '0);
              rf_waddr <= in_rd;
              rf_wdata <= (in_reg_store_sel == WRITE_BACK_SEL_PC) ? in_pc_plus4
                                                                  : in_alu_result;
              retire   <= 1'b1;
            end
          end
        end
        WB_WAIT_MEM: begin
          if (mem_rdata_valid) begin
            rf_we     <= (rd_reg != '0);
            rf_waddr  <= rd_reg;
            rf_wdata  <= load_data;
            retire    <= 1'b1;
            state_reg <= WB_IDLE;
          end
        end
        default: state_reg <= WB_IDLE;
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  // Counts registered retire pulses, so it trails retire by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios followed by
// randomized traffic compared against an arithmetic reference of the load rules.
module tb_write_back_stage;
  import write_back_stage_pkg::*;
  import instr_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic               in_reg_write_en;
  write_back_select_t in_reg_store_sel;
  logic [4:0]         in_rd;
  logic [31:0]        in_alu_result;
  logic [31:0]        in_pc_plus4;
  logic [2:0]         in_load_funct3;
  logic [1:0]         in_addr_low;
  logic               mem_rdata_valid;
  logic [31:0]        mem_rdata;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [31:0]        rf_wdata;
  logic               retire;
`ifdef WB_INSTRET_EN
  logic [63:0]        instret;
`endif

  int checks = 0;
  int errors = 0;
  longint unsigned model_retires = 0;

  always #5 clk = ~clk;

  write_back_stage dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_reg_write_en  (in_reg_write_en),
    .in_reg_store_sel (in_reg_store_sel),
    .in_rd            (in_rd),
    .in_alu_result    (in_alu_result),
    .in_pc_plus4      (in_pc_plus4),
    .in_load_funct3   (in_load_funct3),
    .in_addr_low      (in_addr_low),
    .mem_rdata_valid  (mem_rdata_valid),
    .mem_rdata        (mem_rdata),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
`ifdef WB_INSTRET_EN
    .instret          (instret),
`endif
    .retire           (retire)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference extension computed with plain integer arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int unsigned a,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic present(input logic we, input write_back_select_t sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [2:0] f3, input logic [1:0] al);
    in_valid         = 1'b1;
    in_reg_write_en  = we;
    in_reg_store_sel = sel;
    in_rd            = rd;
    in_alu_result    = alu;
    in_pc_plus4      = pc4;
    in_load_funct3   = f3;
    in_addr_low      = al;
  endtask

  // Non-load instruction: result must appear in the very next cycle.
  task automatic do_simple(input string tag, input logic we, input write_back_select_t sel,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc4);
    logic exp_we;
    present(we, sel, rd, alu, pc4, 3'b010, 2'b00);
    chk({tag, "_ready_pre"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    exp_we = we && (rd != 0);
    model_retires++;
    chk({tag, "_we"}, rf_we, exp_we);
    chk({tag, "_retire"}, retire, 1'b1);
    if (exp_we) begin
      chk({tag, "_waddr"}, rf_waddr, rd);
      chk({tag, "_wdata"}, rf_wdata, (sel == WRITE_BACK_SEL_PC) ? pc4 : alu);
    end
  endtask

  // Load: accepted, waits 'delay' extra cycles, then the response is sampled.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] al, input logic [31:0] word, input int delay);
    present(1'b1, WRITE_BACK_SEL_MEM, rd, $urandom, $urandom, f3, al);
    step();
    in_valid = 1'b0;
    chk({tag, "_ready_wait"}, in_ready, 1'b0);
    chk({tag, "_no_retire"}, retire, 1'b0);
    for (int i = 0; i < delay; i++) begin
      mem_rdata = $urandom;
      step();
      chk({tag, "_ready_hold"}, in_ready, 1'b0);
      chk({tag, "_we_hold"}, rf_we, 1'b0);
    end
    mem_rdata_valid = 1'b1;
    mem_rdata       = word;
    step();
    mem_rdata_valid = 1'b0;
    model_retires++;
    chk({tag, "_we"}, rf_we, rd != 0);
    chk({tag, "_retire"}, retire, 1'b1);
    chk({tag, "_ready_back"}, in_ready, 1'b1);
    if (rd != 0) begin
      chk({tag, "_waddr"}, rf_waddr, rd);
      chk({tag, "_wdata"}, rf_wdata, ref_load(f3, al, word));
    end
  endtask

  initial begin
    reset = 1'b1;
    present(1'b0, WRITE_BACK_SEL_ALU, 5'd0, 32'd0, 32'd0, 3'b000, 2'b00);
    in_valid        = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    step();
    step();
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 5'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_retire", retire, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
`ifdef WB_INSTRET_EN
    chk("rst_instret", instret, 64'd0);
`endif
    reset = 1'b0;
    step();

    do_simple("alu_rd5", 1'b1, WRITE_BACK_SEL_ALU, 5'd5, 32'h1234_5678, 32'h0);

    // JAL then store, back to back
    present(1'b1, WRITE_BACK_SEL_PC, 5'd1, 32'hDEAD_BEEF, 32'h0000_0104, 3'b010, 2'b00);
    step();
    model_retires++;
    chk("jal_ready", in_ready, 1'b1);
    chk("jal_we", rf_we, 1'b1);
    chk("jal_waddr", rf_waddr, 5'd1);
    chk("jal_wdata", rf_wdata, 32'h0000_0104);
    chk("jal_retire", retire, 1'b1);
    present(1'b0, WRITE_BACK_SEL_MEM, 5'd7, 32'h100, 32'h0, 3'b010, 2'b00);
    step();
    in_valid = 1'b0;
    model_retires++;
    chk("store_ready", in_ready, 1'b1);
    chk("store_we", rf_we, 1'b0);
    chk("store_retire", retire, 1'b1);
    step();
    chk("idle_retire", retire, 1'b0);

    do_load("lb", 5'd3, FUNCT3_LB, 2'd2, 32'h0080_0000, 2);
    chk("lb_val", rf_wdata, 32'hFFFF_FF80);
    do_load("lhu", 5'd4, FUNCT3_LHU, 2'd2, 32'h8001_0000, 0);
    chk("lhu_val", rf_wdata, 32'h0000_8001);
    do_load("lh", 5'd4, FUNCT3_LH, 2'd2, 32'h8001_0000, 1);
    chk("lh_val", rf_wdata, 32'hFFFF_8001);
    do_load("lw_x0", 5'd0, FUNCT3_LW, 2'd0, 32'hCAFE_F00D, 0);

    do_simple("alu_rd0", 1'b1, WRITE_BACK_SEL_ALU, 5'd0, 32'h5555_AAAA, 32'h0);

    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'h1111_2222;
    step();
    mem_rdata_valid = 1'b0;
    chk("spur_we", rf_we, 1'b0);
    chk("spur_retire", retire, 1'b0);
    chk("spur_ready", in_ready, 1'b1);

    // Reset while a load is outstanding
    present(1'b1, WRITE_BACK_SEL_MEM, 5'd9, 32'h0, 32'h0, FUNCT3_LW, 2'd0);
    step();
    in_valid = 1'b0;
    chk("rstw_wait", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("rstw_ready_async", in_ready, 1'b1);
    model_retires = 0;
    step();
    reset = 1'b0;
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'h7777_7777;
    step();
    mem_rdata_valid = 1'b0;
    chk("rstw_we", rf_we, 1'b0);
    chk("rstw_retire", retire, 1'b0);
    chk("rstw_ready", in_ready, 1'b1);
`ifdef WB_INSTRET_EN
    chk("instret_zero", instret, 64'd0);
    do_simple("cnt_a", 1'b1, WRITE_BACK_SEL_ALU, 5'd2, 32'h1, 32'h0);
    do_simple("cnt_b", 1'b1, WRITE_BACK_SEL_PC, 5'd3, 32'h0, 32'h8);
    do_simple("cnt_c", 1'b0, WRITE_BACK_SEL_ALU, 5'd4, 32'h2, 32'h0);
    step();
    chk("instret_three", instret, 64'd3);
`endif

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      logic [4:0] rd;
      kind = $urandom_range(0, 5);
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      case (kind)
        0, 1: do_simple("r_alu", 1'($urandom), WRITE_BACK_SEL_ALU, rd, $urandom, $urandom);
        2:    do_simple("r_pc", 1'($urandom), WRITE_BACK_SEL_PC, rd, $urandom, $urandom);
        3:    do_simple("r_memnowe", 1'b0, WRITE_BACK_SEL_MEM, rd, $urandom, $urandom);
        4:    do_load("r_load", rd, 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3));
        default: begin
          mem_rdata_valid = 1'($urandom);
          mem_rdata       = $urandom;
          step();
          mem_rdata_valid = 1'b0;
          chk("r_bubble_we", rf_we, 1'b0);
          chk("r_bubble_retire", retire, 1'b0);
        end
      endcase
    end
`ifdef WB_INSTRET_EN
    step();
    chk("r_instret", instret, 64'(model_retires));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
